// File: rtl/crpa_snapshot.sv
// Triggered capture of NCH-channel samples into RAM with a word-addressed register window.
// DATA is prefetched 2 clk after an RDIDX write or a DATA read; the sample stream is never stalled.
module crpa_snapshot #(
  parameter int unsigned BASEADDR = 0,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned NCH      = 4,
  parameter int unsigned W        = 12
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_data_valid,
  input  logic [NCH*W-1:0]   i_data,
  input  logic [31:0]        i_bus_addr,
  input  logic               i_bus_wr,
  input  logic [31:0]        i_bus_wdata,
  input  logic               i_bus_rd,
  output logic [31:0]        o_bus_rdata,
  input  logic               i_ce,
  input  logic               i_trig,
  output logic               o_busy,
  output logic               o_done_pulse
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_count, r_len, w_eff_len;
  logic               r_done_pulse;
  logic [NCH*W-1:0]   r_ram [DEPTH];
  logic [NCH*W-1:0]   r_ram_q;
  logic [15:0]        r_idx;
  logic [7:0]         r_ch;
  logic [1:0]         r_pf;
  logic               r_rd_valid;
  logic [31:0]        r_data;
  logic [W-1:0]       w_sel;
  logic [31:0]        w_off;
  logic               w_arm, w_abort, w_swtrig, w_wr_len, w_wr_rdidx, w_rd_data;
  logic               w_qual, w_trig_now, w_store, w_last;

  assign w_off      = i_bus_addr - BASEADDR;
  assign w_arm      = i_bus_wr && (w_off == 32'd0) && i_bus_wdata[0];
  assign w_abort    = i_bus_wr && (w_off == 32'd0) && i_bus_wdata[1];
  assign w_swtrig   = i_bus_wr && (w_off == 32'd0) && i_bus_wdata[2];
  assign w_wr_len   = i_bus_wr && (w_off == 32'd1);
  assign w_wr_rdidx = i_bus_wr && (w_off == 32'd3);
  assign w_rd_data  = i_bus_rd && (w_off == 32'd4);

  assign w_eff_len  = ((r_len == '0) || (r_len > CW'(DEPTH))) ? CW'(DEPTH) : r_len;
  assign w_qual     = i_data_valid && i_ce;
  assign w_trig_now = (r_state == S_ARMED) && (i_trig || w_swtrig);
  // The trigger cycle's own sample is stored as sample 0.
  assign w_store    = w_qual && !w_abort && ((r_state == S_CAPTURE) || w_trig_now);
  assign w_last     = w_store && (r_count == (w_eff_len - CW'(1)));

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_arm) w_state_nxt = S_ARMED;
        S_ARMED:   if (w_trig_now) w_state_nxt = w_last ? S_DONE : S_CAPTURE;
        S_CAPTURE: if (w_last) w_state_nxt = S_DONE;
        S_DONE:    if (w_arm) w_state_nxt = S_ARMED;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
    if ((r_state == S_ARMED) || (r_state == S_CAPTURE)) o_busy = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_count      <= '0;
      r_len        <= '0;
      r_done_pulse <= 1'b0;
    end else begin
      r_done_pulse <= w_last;
      if (!w_abort && w_arm && ((r_state == S_IDLE) || (r_state == S_DONE)))
        r_count <= '0;
      else if (w_store)
        r_count <= r_count + CW'(1);
      if (w_wr_len) r_len <= i_bus_wdata[CW-1:0];
    end
  end

  assign o_done_pulse = r_done_pulse;

  always_ff @(posedge i_clk) begin
    if (w_store) r_ram[r_count[AW-1:0]] <= i_data;
    r_ram_q <= r_ram[r_idx[AW-1:0]];
  end

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NCH; c++)
      if (r_ch == 8'(c)) w_sel = r_ram_q[c*W +: W];
  end

  // r_pf tracks the two-stage prefetch: address settles, then RAM output is selected.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_idx      <= '0;
      r_ch       <= '0;
      r_pf       <= '0;
      r_rd_valid <= 1'b0;
      r_data     <= '0;
    end else if (w_wr_rdidx) begin
      r_idx      <= i_bus_wdata[15:0];
      // Channel numbers above 255 saturate; they read as 0 like any channel >= NCH.
      r_ch       <= (i_bus_wdata[31:24] == 8'd0) ? i_bus_wdata[23:16] : 8'hFF;
      r_pf       <= 2'b01;
      r_rd_valid <= 1'b0;
    end else if (w_rd_data) begin
      if (r_ch >= 8'(NCH - 1)) begin
        r_ch  <= '0;
        r_idx <= (r_idx >= 16'(DEPTH - 1)) ? 16'd0 : r_idx + 16'd1;
      end else begin
        r_ch <= r_ch + 8'd1;
      end
      r_pf       <= 2'b01;
      r_rd_valid <= 1'b0;
    end else begin
      r_pf <= {r_pf[0], 1'b0};
      if (r_pf[1]) begin
        r_data     <= 32'($signed(w_sel));
        r_rd_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    o_bus_rdata = '0;
    case (w_off)
      32'd1:   o_bus_rdata = 32'(r_len);
      32'd2:   o_bus_rdata = {16'(r_count), 13'd0, r_rd_valid, r_state};
      32'd3:   o_bus_rdata = {8'd0, r_ch, r_idx};
      32'd4:   o_bus_rdata = r_data;
      default: o_bus_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_crpa_snapshot.sv
// Randomized bench for crpa_snapshot checked against a behavioural capture model.
module tb_crpa_snapshot;
  localparam int DEPTH = 1024;
  localparam int NCH   = 4;
  localparam int W     = 12;
  localparam int AW    = 10;
  localparam int BASE  = 32'h40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn, valid, ce, trig, bwr, brd, busy, done;
  logic [NCH*W-1:0] data;
  logic [31:0]      addr, wdata, rdata;

  crpa_snapshot #(.BASEADDR(BASE), .DEPTH(DEPTH), .NCH(NCH), .W(W)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_data_valid(valid), .i_data(data),
    .i_bus_addr(addr), .i_bus_wr(bwr), .i_bus_wdata(wdata), .i_bus_rd(brd),
    .o_bus_rdata(rdata), .i_ce(ce), .i_trig(trig), .o_busy(busy), .o_done_pulse(done)
  );

  int n_vec = 0, n_err = 0;
  int m_state, m_count, m_len, rb_idx, rb_ch, done_cnt;
  bit m_done;
  logic [NCH*W-1:0] m_ram [DEPTH];
  logic [31:0] last_status, d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int idx, input int ch);
    int v;
    if (ch >= NCH) return 32'd0;
    v = int'((m_ram[idx] >> (ch * W)) & ((1 << W) - 1));
    if (v >= (1 << (W - 1))) v = v - (1 << W);
    return 32'(v);
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_len = 0; m_done = 0; rb_idx = 0; rb_ch = 0;
  endtask

  task automatic model_step();
    int eff;
    bit arm, abt, sw;
    if (!resetn) begin
      model_reset();
      return;
    end
    arm = bwr && (addr == BASE) && wdata[0];
    abt = bwr && (addr == BASE) && wdata[1];
    sw  = bwr && (addr == BASE) && wdata[2];
    eff = (m_len == 0 || m_len > DEPTH) ? DEPTH : m_len;
    m_done = 0;
    if (abt) m_state = 0;
    else if ((m_state == 0 || m_state == 3) && arm) begin
      m_state = 1;
      m_count = 0;
    end else if (m_state == 2 || (m_state == 1 && (trig || sw))) begin
      m_state = 2;
      if (valid && ce) begin
        m_ram[m_count] = data;
        m_count++;
        if (m_count == eff) begin
          m_state = 3;
          m_done = 1;
        end
      end
    end
    if (bwr && (addr == BASE + 1)) m_len = int'(wdata) & ((1 << (AW + 1)) - 1);
  endtask

  task automatic tick();
    logic [31:0] sv;
    model_step();
    @(posedge clk);
    #1;
    sv = addr;
    addr = BASE + 2;
    #1;
    last_status = rdata;
    chk("state", 32'(rdata[1:0]), 32'(m_state));
    chk("count", 32'(rdata[31:16]), 32'(m_count));
    chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
    chk("done_pulse", 32'(done), 32'(m_done));
    if (done) done_cnt++;
    addr = sv;
  endtask

  task automatic peek(input int off, output logic [31:0] v);
    logic [31:0] sv;
    sv = addr;
    addr = BASE + off;
    #1;
    v = rdata;
    addr = sv;
  endtask

  task automatic bus_wr(input int off, input logic [31:0] v);
    addr = BASE + off; wdata = v; bwr = 1'b1;
    tick();
    bwr = 1'b0;
  endtask

  task automatic bus_rd(input int off, output logic [31:0] v);
    addr = BASE + off; brd = 1'b1;
    #1;
    v = rdata;
    tick();
    brd = 1'b0;
  endtask

  task automatic set_rdidx(input int idx, input int ch);
    bus_wr(3, {8'h0, 8'(ch), 16'(idx)});
    rb_idx = idx; rb_ch = ch;
    chk("rdv_clr", 32'(last_status[2]), 32'd0);
    tick();
    chk("rdv_1clk", 32'(last_status[2]), 32'd0);
    tick();
    chk("rdv_2clk", 32'(last_status[2]), 32'd1);
  endtask

  task automatic read_data(output logic [31:0] v);
    bus_rd(4, v);
    chk($sformatf("data[%0d.%0d]", rb_idx, rb_ch), v, exp_rd(rb_idx, rb_ch));
    if (rb_ch >= NCH - 1) begin
      rb_ch = 0;
      rb_idx = (rb_idx + 1) % DEPTH;
    end else rb_ch++;
    tick();
    tick();
    chk("rdv_prefetch", 32'(last_status[2]), 32'd1);
  endtask

  task automatic rand_data();
    for (int c = 0; c < NCH; c++) data[c*W +: W] = W'($urandom);
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (m_state != 3 && n < budget) begin
      rand_data();
      tick();
      n++;
    end
    chk("done_in_budget", 32'(m_state), 32'd3);
  endtask

  initial begin
    resetn = 1'b0; valid = 0; ce = 0; trig = 0; bwr = 0; brd = 0;
    data = '0; addr = BASE; wdata = '0;
    model_reset();
    #1;
    peek(2, d); chk("rst_status", d, 32'd0);
    peek(3, d); chk("rst_rdidx", d, 32'd0);
    peek(4, d); chk("rst_data", d, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    peek(1, d); chk("rst_len", d, 32'd0);

    // LEN=8 ramp on ch0
    bus_wr(1, 32'd8);
    bus_wr(0, 32'd1);
    trig = 1; valid = 1; ce = 1; done_cnt = 0;
    for (int k = 0; k < 40 && m_state != 3; k++) begin
      rand_data();
      data[0 +: W] = W'(k);
      tick();
    end
    valid = 0; trig = 0;
    tick(); tick(); tick();
    chk("ramp_done_cnt", 32'(done_cnt), 32'd1);
    peek(2, d);
    chk("ramp_state", 32'(d[1:0]), 32'd3);
    chk("ramp_count", 32'(d[31:16]), 32'd8);
    for (int k = 0; k < 8; k++) begin
      set_rdidx(k, 0);
      read_data(d);
      chk("ramp_val", d, 32'(k));
    end

    // ce toggling: only every other value is stored
    bus_wr(1, 32'd4);
    bus_wr(0, 32'd1);
    trig = 1; valid = 1;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      data[0 +: W] = W'(10 + k);
      ce = (k % 2 == 0);
      tick();
    end
    valid = 0; trig = 0; ce = 1;
    peek(2, d);
    chk("ce_state", 32'(d[1:0]), 32'd3);
    chk("ce_count", 32'(d[31:16]), 32'd4);
    for (int k = 0; k < 4; k++) begin
      set_rdidx(k, 0);
      read_data(d);
      chk("ce_val", d, 32'(10 + 2 * k));
    end

    // ARM with trig in the same cycle: trigger ignored
    bus_wr(1, 32'd4);
    valid = 1; trig = 1;
    rand_data();
    bus_wr(0, 32'd1);
    peek(2, d); chk("armtrig_state", 32'(d[1:0]), 32'd1);
    trig = 0;
    rand_data(); tick();
    rand_data(); tick();
    peek(2, d); chk("armtrig_wait", 32'(d[1:0]), 32'd1);
    trig = 1;
    rand_data();
    data[0 +: W] = 12'h5A5;
    tick();
    trig = 0;
    run_to_done(10);
    valid = 0;
    set_rdidx(0, 0);
    read_data(d);
    chk("trig_sample0", d, 32'h5A5);

    // ARM|ABORT in DONE and negative sample readback
    bus_wr(1, 32'd2);
    valid = 1;
    rand_data();
    data[W +: W] = 12'hF00;
    bus_wr(0, 32'd1);
    trig = 1;
    tick();
    trig = 0;
    run_to_done(10);
    valid = 0;
    bus_wr(0, 32'd3);
    peek(2, d);
    chk("abort_state", 32'(d[1:0]), 32'd0);
    chk("abort_count", 32'(d[31:16]), 32'd2);
    set_rdidx(0, 1);
    read_data(d);
    chk("neg_sample", d, 32'hFFFFFF00);

    // Reset in the middle of a capture
    bus_wr(1, 32'd0);
    bus_wr(0, 32'd1);
    trig = 1; valid = 1;
    for (int k = 0; k < 100 && m_count != 37; k++) begin
      rand_data();
      tick();
    end
    chk("pre_rst_count", 32'(m_count), 32'd37);
    resetn = 1'b0;
    #1;
    model_reset();
    peek(2, d); chk("midrst_status", d, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick(); tick();
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      tick();
    end
    trig = 0;

    // LEN=0 captures the full depth
    bus_wr(1, 32'd0);
    bus_wr(0, 32'd1);
    trig = 1;
    run_to_done(1100);
    trig = 0; valid = 0;
    peek(2, d);
    chk("full_state", 32'(d[1:0]), 32'd3);
    chk("full_count", 32'(d[31:16]), 32'(DEPTH));
    set_rdidx(DEPTH - 1, NCH - 1);
    read_data(d);
    read_data(d);
    chk("wrap_val", d, exp_rd(0, 0));
    peek(3, d);
    chk("wrap_rdidx", d, 32'h0001_0000);
    repeat (6) begin
      set_rdidx(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, NCH + 1)));
      read_data(d);
    end

    // Unmapped offsets and LEN width
    bus_wr(7, 32'hFFFF_FFFF);
    peek(1, d); chk("unmapped_len", d, 32'(m_len));
    peek(7, d); chk("unmapped_rd", d, 32'd0);
    bus_wr(1, 32'h0000_FFFF);
    peek(1, d); chk("len_mask", d, 32'h7FF);

    // Random traffic
    bus_wr(1, 32'd5);
    repeat (400) begin
      int r;
      rand_data();
      valid = ($urandom_range(0, 3) != 0);
      ce    = ($urandom_range(0, 1) == 1);
      trig  = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 15));
      if (r == 0)      bus_wr(0, 32'($urandom_range(0, 7)));
      else if (r == 1) bus_wr(1, 32'($urandom_range(1, 12)));
      else             tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
